// File: rtl/hann_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hann_pkg
// Description : Definitions shared by the Hann window coefficient writer and
//               the coefficient reader. Holds the load FSM state encoding and
//               the default table geometry.
// Revision    : 1.0  initial release
// ============================================================================
package hann_pkg;

    // Default table geometry; DEPTH is always 2**ADDR_WIDTH.
    localparam int HANN_DEPTH      = 128;
    localparam int HANN_ADDR_WIDTH = 7;
    localparam int HANN_DATA_WIDTH = 16;

    // Load FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } hann_state_t;

endpackage
`default_nettype wire

// File: rtl/hann_coef_writer.sv
`default_nettype none
// ============================================================================
// Module      : hann_coef_writer
// Description : Loads the Hann window coefficient table from a valid/ready
//               stream into a single-port RAM write port (addresses
//               0..DEPTH-1), checks the frame length against DEPTH and
//               reports completion (done) and the outcome (table_valid,
//               err_len).
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               start            - arm a load (honoured only when idle)
//               s_tvalid/s_tready/s_tdata/s_tlast - coefficient stream
//               wr_en/wr_addr/wr_data - RAM write port, one cycle behind
//                                  the accepting handshake
//               busy             - load or flush in progress
//               done             - one-cycle pulse at the end of every load
//               table_valid      - last load was complete and exact
//               err_len          - sticky frame-length error
//               checksum         - only with HANN_WR_CHECKSUM_EN: running
//                                  sum of every written coefficient
// Options     : HANN_WR_CHECKSUM_EN adds the checksum port and accumulator.
// Revision    : 1.0  initial release
// ============================================================================
module hann_coef_writer
    import hann_pkg::*;
#(
    parameter int ADDR_WIDTH = HANN_ADDR_WIDTH,
    parameter int DATA_WIDTH = HANN_DATA_WIDTH,
    parameter int DEPTH      = HANN_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tlast,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  table_valid,
    output logic                  err_len
`ifdef HANN_WR_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH+ADDR_WIDTH-1:0] checksum
`endif
);

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(DEPTH - 1);

    hann_state_t           r_state;
    hann_state_t           w_state_next;
    logic [ADDR_WIDTH-1:0] r_count;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_table_valid;
    logic                  r_err_len;

    logic w_hs;
    logic w_load_hs;
    logic w_at_last;
    logic w_start_acc;
    logic w_len_err;

    // Ready depends on state only, never on s_tvalid.
    assign s_tready    = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
    assign w_hs        = s_tvalid && s_tready;
    assign w_load_hs   = w_hs && (r_state == ST_LOAD);
    assign w_at_last   = (r_count == c_last_addr);
    assign w_start_acc = start && (r_state == ST_IDLE);
    // tlast before the last address is a short frame; no tlast on the last
    // address is a long frame. Both are the same mismatch.
    assign w_len_err   = w_load_hs && (s_tlast != w_at_last);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_hs) begin
                    if (s_tlast) begin
                        w_state_next = ST_DONE;
                    end else if (w_at_last) begin
                        w_state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_hs && s_tlast) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Beat counter: saturates at the last address because reaching it
    // always leaves LOAD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_start_acc) begin
            r_count <= '0;
        end else if (w_load_hs && !s_tlast && !w_at_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write register: one cycle behind the handshake. Address and data
    // hold their last written value between writes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_load_hs;
            if (w_load_hs) begin
                r_wr_addr <= r_count;
                r_wr_data <= s_tdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status. busy and done are registered from the next state so they
    // line up with the state they describe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_table_valid <= 1'b0;
            r_err_len     <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_LOAD) || (w_state_next == ST_FLUSH);
            r_done <= (w_state_next == ST_DONE);

            if (w_start_acc) begin
                r_err_len <= 1'b0;
            end else if (w_len_err) begin
                r_err_len <= 1'b1;
            end

            // Entering DONE with no error recorded so far and none on the
            // final beat means the table is complete.
            if (w_start_acc) begin
                r_table_valid <= 1'b0;
            end else if ((w_state_next == ST_DONE) && (r_state != ST_DONE) &&
                         !r_err_len && !w_len_err) begin
                r_table_valid <= 1'b1;
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign busy        = r_busy;
    assign done        = r_done;
    assign table_valid = r_table_valid;
    assign err_len     = r_err_len;

`ifdef HANN_WR_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Checksum over written coefficients only (flushed beats excluded),
    // updated on the same edge as wr_en.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_load_hs) begin
            r_checksum <= r_checksum + {{ADDR_WIDTH{1'b0}}, s_tdata};
        end
    end

    assign checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hann_coef_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hann_coef_writer
// Description : Self-checking bench for hann_coef_writer. Frames are streamed
//               with optional stalls; a reference model derived from the
//               frame length predicts the writes, completion and flags.
// Options     : HANN_WR_CHECKSUM_EN enables the checksum scenario.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hann_coef_writer;

    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          table_valid;
    logic          err_len;
`ifdef HANN_WR_CHECKSUM_EN
    logic [DW+AW-1:0] checksum;
`endif

    hann_coef_writer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tlast     (s_tlast),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .table_valid (table_valid),
        .err_len     (err_len)
`ifdef HANN_WR_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed activity, sampled on the falling edge.
    int            wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            wr_cyc_q[$];
    int            done_cyc_q[$];
    logic          tv_done_q[$];
    logic          err_done_q[$];
    int            hs_cyc_q[$];
    logic [DW-1:0] frame_data [0:299];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_addr_q.push_back(int'(wr_addr));
            wr_data_q.push_back(wr_data);
            wr_cyc_q.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            tv_done_q.push_back(table_valid);
            err_done_q.push_back(err_len);
        end
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
        tv_done_q.delete();
        err_done_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Streams beats 0..nbeats-1 of frame_data; tlast on beat last_idx.
    // stall: 0 none, 1 valid low every third cycle, 2 random gaps.
    task automatic send_frame(input int nbeats, input int last_idx,
                              input int stall, input bit hold_start);
        int   k = 0;
        int   guard = 0;
        logic v;
        start = hold_start;
        while (k < nbeats && guard < 4000) begin
            case (stall)
                1:       v = ((guard % 3) != 2);
                2:       v = ($urandom_range(0, 3) != 0);
                default: v = 1'b1;
            endcase
            s_tvalid = v;
            s_tdata  = v ? frame_data[k] : DW'($urandom);
            s_tlast  = v ? (k == last_idx) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (v && s_tready === 1'b1) begin
                hs_cyc_q.push_back(cyc);
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        start    = 1'b0;
        n_checks++;
        if (k != nbeats) begin
            n_fail++;
            $display("FAIL stream_timeout: accepted %0d beats, required %0d", k, nbeats);
        end
    endtask

    // One complete load of nbeats beats (tlast on the final beat), checked
    // against the model: min(nbeats, DEPTH) writes in address order, each one
    // cycle after its handshake; done one cycle after the final handshake;
    // the load is good exactly when nbeats == DEPTH.
    task automatic test_frame(input string name, input int nbeats, input int stall,
                              input bit do_start, input bit hold_start);
        int            n_wr;
        bit            good;
        int            n_cmp;
        int            shown = 0;
        logic [DW+AW-1:0] sum = '0;
        clear_mon();
        if (do_start) pulse_start();
        n_checks++;
        if (s_tready !== 1'b1 || busy !== 1'b1 || err_len !== 1'b0 || table_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s armed: tready=%b busy=%b err=%b tv=%b, required 1 1 0 0",
                     name, s_tready, busy, err_len, table_valid);
        end
        send_frame(nbeats, nbeats - 1, stall, hold_start);
        repeat (3) @(posedge clk);
        #1;

        n_wr = (nbeats < DEPTH) ? nbeats : DEPTH;
        good = (nbeats == DEPTH);
        for (int i = 0; i < n_wr; i++) sum += {{AW{1'b0}}, frame_data[i]};

        n_checks++;
        if (wr_addr_q.size() != n_wr) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d, required %0d", name, wr_addr_q.size(), n_wr);
        end
        n_cmp = wr_addr_q.size();
        if (n_cmp > n_wr) n_cmp = n_wr;
        if (n_cmp > hs_cyc_q.size()) n_cmp = hs_cyc_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            n_checks++;
            if (wr_addr_q[i] != i || wr_data_q[i] !== frame_data[i] ||
                wr_cyc_q[i] != hs_cyc_q[i] + 1) begin
                n_fail++;
                if (shown < 8) begin
                    shown++;
                    $display("FAIL %s write[%0d]: addr=%0d data=%h cyc=%0d, required addr=%0d data=%h cyc=%0d",
                             name, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i],
                             i, frame_data[i], hs_cyc_q[i] + 1);
                end
            end
        end

        n_checks++;
        if (done_cyc_q.size() != 1 || hs_cyc_q.size() != nbeats ||
            done_cyc_q[0] != hs_cyc_q[nbeats-1] + 1) begin
            n_fail++;
            $display("FAIL %s done_timing: %0d pulses, first at %0d, required 1 pulse at %0d",
                     name, done_cyc_q.size(),
                     (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1,
                     (hs_cyc_q.size() > 0) ? hs_cyc_q[hs_cyc_q.size()-1] + 1 : -1);
        end else begin
            n_checks++;
            if (tv_done_q[0] !== good || err_done_q[0] !== !good) begin
                n_fail++;
                $display("FAIL %s flags_at_done: tv=%b err=%b, required tv=%b err=%b",
                         name, tv_done_q[0], err_done_q[0], good, !good);
            end
        end

        n_checks++;
        if (s_tready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            table_valid !== good || err_len !== !good) begin
            n_fail++;
            $display("FAIL %s idle_after: tready=%b busy=%b done=%b tv=%b err=%b, required 0 0 0 %b %b",
                     name, s_tready, busy, done, table_valid, err_len, good, !good);
        end
`ifdef HANN_WR_CHECKSUM_EN
        n_checks++;
        if (checksum !== sum) begin
            n_fail++;
            $display("FAIL %s checksum: got %h, required %h", name, checksum, sum);
        end
`else
        if (sum == '1) $display("note: all-ones coefficient sum in %s", name);
`endif
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (s_tready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || table_valid !== 1'b0 || err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: tready=%b wr_en=%b addr=%h data=%h busy=%b done=%b tv=%b err=%b, required all 0",
                     s_tready, wr_en, wr_addr, wr_data, busy, done, table_valid, err_len);
        end
`ifdef HANN_WR_CHECKSUM_EN
        n_checks++;
        if (checksum !== '0) begin
            n_fail++;
            $display("FAIL reset_checksum: got %h, required 0", checksum);
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Beats without start are never accepted.
        s_tvalid = 1'b1;
        s_tdata  = 16'h1234;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (s_tready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_accept: tready=%b wr_en=%b busy=%b, required 0 0 0",
                     s_tready, wr_en, busy);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic test_good_load();
        for (int k = 0; k < DEPTH; k++) frame_data[k] = DW'(3 * k);
        // A beat presented with start must not be taken in that cycle.
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = 16'hDEAD;
        start    = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL beat_with_start: tready=%b, required 0", s_tready);
        end
        @(posedge clk); #1;
        start    = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        test_frame("good_load", DEPTH, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stalls();
        for (int k = 0; k < DEPTH; k++) frame_data[k] = DW'(3 * k);
        test_frame("stalls", DEPTH, 1, 1'b1, 1'b0);
    endtask

    task automatic test_short_frame();
        for (int k = 0; k < 10; k++) frame_data[k] = DW'($urandom);
        test_frame("short_frame", 10, 0, 1'b1, 1'b0);
    endtask

    task automatic test_long_frame();
        for (int k = 0; k < 130; k++) frame_data[k] = DW'($urandom);
        test_frame("long_frame", 130, 0, 1'b1, 1'b0);
    endtask

    // start held high for the whole frame must neither restart nor clear.
    task automatic test_start_ignored();
        for (int k = 0; k < DEPTH; k++) frame_data[k] = DW'($urandom);
        test_frame("start_ignored", DEPTH, 2, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        clear_mon();
        for (int k = 0; k < 51; k++) frame_data[k] = DW'($urandom | 1);
        pulse_start();
        send_frame(51, -1, 0, 1'b0);
        // Beat 50's write is in the output register now; reset drops it.
        rst = 1'b1;
        #1;
        n_checks++;
        if (s_tready !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 ||
            busy !== 1'b0 || done !== 1'b0 || table_valid !== 1'b0 || err_len !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: tready=%b wr_en=%b addr=%h data=%h busy=%b done=%b tv=%b err=%b, required all 0",
                     s_tready, wr_en, wr_addr, wr_data, busy, done, table_valid, err_len);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (s_tready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: tready=%b busy=%b, required 0 0", s_tready, busy);
        end
        for (int k = 0; k < DEPTH; k++) frame_data[k] = DW'($urandom);
        test_frame("after_reset", DEPTH, 0, 1'b1, 1'b0);
    endtask

    task automatic test_random_frames();
        int n;
        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 2))
                0:       n = $urandom_range(1, DEPTH - 1);
                1:       n = DEPTH;
                default: n = $urandom_range(DEPTH + 1, DEPTH + 12);
            endcase
            for (int k = 0; k < n; k++) frame_data[k] = DW'($urandom);
            test_frame($sformatf("random%0d_len%0d", it, n), n, 2, 1'b1, 1'b0);
        end
    endtask

`ifdef HANN_WR_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < DEPTH; k++) frame_data[k] = 16'h0100;
        test_frame("checksum_load", DEPTH, 0, 1'b1, 1'b0);
        n_checks++;
        if (checksum !== 23'h008000) begin
            n_fail++;
            $display("FAIL checksum_value: got %h, required 008000", checksum);
        end
        pulse_start();
        n_checks++;
        if (checksum !== '0) begin
            n_fail++;
            $display("FAIL checksum_clear: got %h, required 0", checksum);
        end
        // Close the armed load with a one-beat frame.
        frame_data[0] = 16'h0000;
        send_frame(1, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_good_load();
        test_stalls();
        test_short_frame();
        test_long_frame();
        test_start_ignored();
        test_reset_mid();
        test_random_frames();
`ifdef HANN_WR_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
